// File: rtl/id_ex_alu_encoder.sv
// Decode stage ALU-control encoder and ID/EX control pipeline register.
// Produces ALUOp/Funct plus main control bits, with load-use hazard detection and bubble insertion.
module id_ex_alu_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        hazard_stall,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Funct,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        Branch,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic        ex_valid,
  output logic        illegal_instr,
  output logic [15:0] bubble_count
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic [1:0] aluop;
    logic [3:0] funct;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       valid;
  } idex_t;

  opcode_e     op;
  logic [2:0]  f3;
  logic        f7b;
  idex_t       dec;
  logic        legal;
  logic        uses_rs2;

  idex_t       ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [15:0] bcnt_inc;

  assign op  = opcode_e'(instr_in[6:0]);
  assign f3  = instr_in[14:12];
  assign f7b = instr_in[30];

  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    uses_rs2  = 1'b0;
    dec.rs1   = instr_in[19:15];
    dec.rs2   = instr_in[24:20];
    dec.rd    = instr_in[11:7];
    dec.valid = 1'b1;
    case (op)
      OP_R: begin
        dec.aluop    = 2'b10;
        dec.funct    = {f7b, f3};
        dec.regwrite = 1'b1;
        uses_rs2     = 1'b1;
        legal        = (dec.funct == 4'b0000) || (dec.funct == 4'b1000) ||
                       (dec.funct == 4'b0111) || (dec.funct == 4'b0110);
      end
      OP_I: begin
        dec.funct    = {1'b0, f3};
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        legal        = (f3 == 3'b000) || (f3 == 3'b001);
      end
      OP_LOAD: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        legal        = 1'b1;
      end
      OP_STORE: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        uses_rs2     = 1'b1;
        legal        = 1'b1;
      end
      OP_BRANCH: begin
        dec.aluop    = 2'b01;
        dec.funct    = {1'b0, f3};
        dec.branch   = 1'b1;
        uses_rs2     = 1'b1;
        legal        = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100);
      end
      default: legal = 1'b0;
    endcase
  end

  // rs2 only participates in the hazard for formats that actually read it
  assign hazard_stall = !flush && instr_valid && ctrl_q.valid && ctrl_q.memread &&
                        (ctrl_q.rd != 5'd0) &&
                        ((ctrl_q.rd == instr_in[19:15]) ||
                         (uses_rs2 && (ctrl_q.rd == instr_in[24:20])));

  assign bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

  always_comb begin
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    bcnt_d    = bcnt_q;
    if (flush) begin
      ctrl_d = '0;
      bcnt_d = bcnt_inc;
    end else if (stall) begin
      ctrl_d = ctrl_q;
    end else if (hazard_stall) begin
      ctrl_d = '0;
      bcnt_d = bcnt_inc;
    end else if (!instr_valid) begin
      ctrl_d = '0;
    end else if (!legal) begin
      ctrl_d    = '0;
      illegal_d = 1'b1;
      bcnt_d    = bcnt_inc;
    end else begin
      ctrl_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign ALUOp         = ctrl_q.aluop;
  assign Funct         = ctrl_q.funct;
  assign RegWrite      = ctrl_q.regwrite;
  assign MemRead       = ctrl_q.memread;
  assign MemWrite      = ctrl_q.memwrite;
  assign MemtoReg      = ctrl_q.memtoreg;
  assign ALUSrc        = ctrl_q.alusrc;
  assign Branch        = ctrl_q.branch;
  assign rs1_ex        = ctrl_q.rs1;
  assign rs2_ex        = ctrl_q.rs2;
  assign rd_ex         = ctrl_q.rd;
  assign ex_valid      = ctrl_q.valid;
  assign illegal_instr = illegal_q;
  assign bubble_count  = bcnt_q;

endmodule

// File: tb/tb_id_ex_alu_encoder.sv
// Directed self-checking bench for id_ex_alu_encoder.
module tb_id_ex_alu_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid, stall, flush;
  logic        hazard_stall;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic        ex_valid, illegal_instr;
  logic [15:0] bubble_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] SLLI = 32'h00209093;
  localparam logic [31:0] BNE  = 32'h00209063;
  localparam logic [31:0] LW   = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;
  localparam logic [31:0] SLLR = 32'h002091B3;

  id_ex_alu_encoder dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .hazard_stall(hazard_stall),
    .ALUOp(ALUOp), .Funct(Funct), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .ex_valid(ex_valid),
    .illegal_instr(illegal_instr), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; instr_in = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    chk("rst_aluop", 32'(ALUOp), 0);
    chk("rst_funct", 32'(Funct), 0);
    chk("rst_exv", 32'(ex_valid), 0);
    chk("rst_bcnt", 32'(bubble_count), 0);
    chk("rst_haz", 32'(hazard_stall), 0);
    reset = 1'b1;

    instr_in = ADD; instr_valid = 1'b1;
    step();
    chk("add_aluop", 32'(ALUOp), 2);
    chk("add_funct", 32'(Funct), 0);
    chk("add_rd", 32'(rd_ex), 3);
    chk("add_rs1", 32'(rs1_ex), 1);
    chk("add_rs2", 32'(rs2_ex), 2);
    chk("add_regw", 32'(RegWrite), 1);
    chk("add_exv", 32'(ex_valid), 1);
    instr_in = SUB;
    step();
    chk("sub_funct", 32'(Funct), 8);

    instr_in = SLLI;
    step();
    chk("slli_aluop", 32'(ALUOp), 0);
    chk("slli_funct", 32'(Funct), 1);
    chk("slli_alusrc", 32'(ALUSrc), 1);
    instr_in = BNE;
    step();
    chk("bne_aluop", 32'(ALUOp), 1);
    chk("bne_funct", 32'(Funct), 1);
    chk("bne_branch", 32'(Branch), 1);
    chk("bne_regw", 32'(RegWrite), 0);

    // load-use
    instr_in = LW;
    #1 chk("lw_nohaz", 32'(hazard_stall), 0);
    step();
    chk("lw_memread", 32'(MemRead), 1);
    chk("lw_memtoreg", 32'(MemtoReg), 1);
    chk("lw_rd", 32'(rd_ex), 5);
    instr_in = ADD6;
    #1 chk("lu_haz", 32'(hazard_stall), 1);
    step();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_bcnt", 32'(bubble_count), 1);
    chk("lu_haz_drop", 32'(hazard_stall), 0);
    step();
    chk("lu_issue_exv", 32'(ex_valid), 1);
    chk("lu_issue_rs1", 32'(rs1_ex), 5);
    chk("lu_issue_rd", 32'(rd_ex), 6);

    // flush wins over stall
    flush = 1'b1; stall = 1'b1; instr_in = ADD;
    #1 chk("fl_haz", 32'(hazard_stall), 0);
    step();
    chk("fl_exv", 32'(ex_valid), 0);
    chk("fl_aluop", 32'(ALUOp), 0);
    chk("fl_bcnt", 32'(bubble_count), 2);
    flush = 1'b0; stall = 1'b0;

    // stall holds
    step();
    chk("st_pre_aluop", 32'(ALUOp), 2);
    stall = 1'b1; instr_in = SUB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_funct", 32'(Funct), 0);
      chk("st_aluop", 32'(ALUOp), 2);
      chk("st_bcnt", 32'(bubble_count), 2);
    end
    stall = 1'b0;
    step();
    chk("st_rel_funct", 32'(Funct), 8);

    // illegal opcode, sticky flag
    instr_in = 32'hFFFFFFFF;
    step();
    chk("ill_exv", 32'(ex_valid), 0);
    chk("ill_flag", 32'(illegal_instr), 1);
    chk("ill_bcnt", 32'(bubble_count), 3);
    instr_in = ADD;
    step();
    chk("ill_sticky", 32'(illegal_instr), 1);
    chk("ill_after_exv", 32'(ex_valid), 1);
    instr_valid = 1'b0;
    step();
    chk("inv_exv", 32'(ex_valid), 0);
    chk("inv_bcnt", 32'(bubble_count), 3);
    instr_valid = 1'b1; instr_in = SLLR;
    step();
    chk("illf_exv", 32'(ex_valid), 0);
    chk("illf_bcnt", 32'(bubble_count), 4);

    // mid-run reset
    reset = 1'b0; instr_in = ADD;
    step();
    chk("r2_aluop", 32'(ALUOp), 0);
    chk("r2_regw", 32'(RegWrite), 0);
    chk("r2_rd", 32'(rd_ex), 0);
    chk("r2_exv", 32'(ex_valid), 0);
    chk("r2_ill", 32'(illegal_instr), 0);
    chk("r2_bcnt", 32'(bubble_count), 0);
    chk("r2_haz", 32'(hazard_stall), 0);
    reset = 1'b1;

    // saturation
    instr_valid = 1'b0; flush = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat_fffe", 32'(bubble_count), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(bubble_count), 32'hFFFF);
    step();
    chk("sat_hold_fl", 32'(bubble_count), 32'hFFFF);
    flush = 1'b0; instr_valid = 1'b1; instr_in = LW;
    step();
    instr_in = ADD6;
    #1 chk("sat_haz", 32'(hazard_stall), 1);
    step();
    chk("sat_hold_hz", 32'(bubble_count), 32'hFFFF);
    chk("sat_hz_exv", 32'(ex_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
